// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream
// (N[15:8], N[7:0], 4*N data bytes MSB-first, checksum byte), writes each
// assembled 32-bit word into instruction memory, and releases the CPU
// only after a load whose 8-bit running sum matches the trailing checksum.
//
// Handshake: a byte moves only on a clock edge where in_valid && in_ready.
// in_ready is decoded from the registered state, so it never depends on
// in_valid in the same cycle.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_run,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // 17 bits so that DEPTH = 65536 is representable.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  // Only the first three bytes of a word are buffered; the fourth goes
  // straight into the write-data register.
  logic [23:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] wl_q, wl_d;

  logic        xfer;
  logic [15:0] n_hdr;

  assign xfer  = in_valid && in_ready;
  assign n_hdr = {len_hi_q, in_data};

  // State register and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wl_q     <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      asm_q    <= asm_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wl_q     <= wl_d;
    end
  end

  // Next-state logic: header capture, word assembly, write issue, checksum.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wl_d     = wl_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          wl_d    = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          len_d = n_hdr;
          if ({1'b0, n_hdr} > DEPTH_W) begin
            state_d = S_ERR;
          end else if (n_hdr == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          sum_d = sum_q + in_data;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    asm_d[23:16] = in_data;
            2'd1:    asm_d[15:8]  = in_data;
            2'd2:    asm_d[7:0]   = in_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = {14'b0, wl_q, 2'b00};
              wdata_d = {asm_q, in_data};
              wl_d    = wl_q + 16'd1;
              if (wl_q == len_q - 16'd1) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready     = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
  assign busy         = in_ready;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign cpu_run      = done;
  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign words_loaded = wl_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole-load vectors plus hand-written
// sequences for backpressure, mid-load start, mid-load reset and a
// full-depth load. Expected memory writes go into exp_q as bytes are driven
// and are compared when the loader pulses im_we.
module tb_imem_loader;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_run;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state_o;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [15:0] exp_wl = '0;
  logic [7:0]  stream_q[$];
  int          gap_max  = 0;
  int          start_at = -1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst) begin
      check("busy_eq_in_ready", 32'(busy), 32'(in_ready));
      check("cpu_run_eq_done", 32'(cpu_run), 32'(done));
      if (im_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected",
                   im_addr, im_wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          exp_wl  = exp_wl + 16'd1;
          check("write_addr", im_addr, mon_exp[63:32]);
          check("write_data", im_wdata, mon_exp[31:0]);
          check("words_loaded_at_write", 32'(words_loaded), 32'(exp_wl));
        end
        n_checks++;
        if (im_addr > 32'((DEPTH - 1) * 4)) begin
          n_fail++;
          $display("FAIL addr_bound: got 0x%08h, limit 0x%08h", im_addr, 32'((DEPTH - 1) * 4));
        end
      end
    end
  end

  task automatic pulse_start();
    start  = 1'b1;
    exp_wl = '0;
    @(negedge clk);
    start = 1'b0;
    check("start_clears_flags", {29'b0, done, err, cpu_run}, 32'd0);
    check("start_clears_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%02h", b);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drives stream_q and pushes the writes a correct loader must produce.
  task automatic drive_stream();
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  b;
    n = '0;
    w = '0;
    for (int i = 0; i < stream_q.size(); i++) begin
      b = stream_q[i];
      if (i == 0) n[15:8] = b;
      else if (i == 1) n[7:0] = b;
      else if (32'(n) <= 32'(DEPTH) && i < 2 + 4 * int'(n)) begin
        w = {w[23:0], b};
        if ((i - 2) % 4 == 3) exp_q.push_back({32'(((i - 2) / 4) * 4), w});
      end
      send_byte(b);
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy", 32'(busy), 32'd1);
        check("mid_start_state", 32'(dbg_state_o), 32'(ST_DATA));
      end
    end
  endtask

  task automatic run_load(input string name, input logic e_done, input logic e_err,
                          input logic [15:0] e_wl);
    pulse_start();
    drive_stream();
    check({name, "_done"}, 32'(done), 32'(e_done));
    check({name, "_err"}, 32'(err), 32'(e_err));
    check({name, "_cpu_run"}, 32'(cpu_run), 32'(e_done));
    check({name, "_words"}, 32'(words_loaded), 32'(e_wl));
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, 32'(done), 32'(e_done));
    check({name, "_err_hold"}, 32'(err), 32'(e_err));
  endtask

  task automatic load_good_stream();
    logic [87:0] g;
    g = 88'h0002_2008_0005_0000_0000_2D;
    stream_q.delete();
    for (int i = 0; i < 11; i++) stream_q.push_back(g[8 * (10 - i) +: 8]);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {26'b0, busy, in_ready, im_we, done, err, cpu_run}, 32'd0);
    check({name, "_addr"}, im_addr, 32'd0);
    check({name, "_wdata"}, im_wdata, 32'd0);
    check({name, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [87:0] bytes;
    int          nbytes;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_wl;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] sum;
    logic [7:0] r;

    vecs[0] = '{"good",     88'h0002_2008_0005_0000_0000_2D, 11, 1'b1, 1'b0, 16'd2};
    vecs[1] = '{"bad_csum", 88'h0002_2008_0005_0000_0000_2C, 11, 1'b0, 1'b1, 16'd2};
    vecs[2] = '{"oversize", 88'h0101,                         2, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{"empty",    88'h0000_00,                      3, 1'b1, 1'b0, 16'd0};
    vecs[4] = '{"one_word", 88'h0001_DEAD_BEEF_38,            7, 1'b1, 1'b0, 16'd1};

    // Reset block.
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state_o), 32'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk);
    check("idle_not_ready", 32'(in_ready), 32'd0);

    // Table-driven whole loads.
    for (int v = 0; v < 5; v++) begin
      stream_q.delete();
      for (int i = 0; i < vecs[v].nbytes; i++)
        stream_q.push_back(vecs[v].bytes[8 * (vecs[v].nbytes - 1 - i) +: 8]);
      run_load(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wl);
    end

    // Random gaps on in_valid and a start pulse in the middle of DATA.
    gap_max  = 3;
    start_at = 4;
    load_good_stream();
    run_load("gaps_mid_start", 1'b1, 1'b0, 16'd2);
    gap_max  = 0;
    start_at = -1;

    // Reset after five data bytes, then a clean load.
    pulse_start();
    load_good_stream();
    for (int i = 0; i < 4; i++) void'(stream_q.pop_back());
    drive_stream();
    check("pre_reset_words", 32'(words_loaded), 32'd1);
    check("pre_reset_queue_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    check_all_zero("mid_reset_held");
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_cpu_run", 32'(cpu_run), 32'd0);
    check("post_reset_state", 32'(dbg_state_o), 32'(ST_IDLE));
    load_good_stream();
    run_load("after_reset", 1'b1, 1'b0, 16'd2);

    // Largest legal program: N == DEPTH, random contents.
    stream_q.delete();
    stream_q.push_back(8'(DEPTH >> 8));
    stream_q.push_back(8'(DEPTH & 255));
    sum = '0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      r   = 8'($urandom_range(0, 255));
      sum = sum + r;
      stream_q.push_back(r);
    end
    stream_q.push_back(sum);
    run_load("full_depth", 1'b1, 1'b0, 16'(DEPTH));
    check("full_depth_last_addr", im_addr, 32'((DEPTH - 1) * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 256, instruction-memory capacity in 32-bit words (power of two, 2..65536).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a load.
REQ-005 in_valid  input  1  byte-stream data valid.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 im_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 im_addr  output  32  byte address of the written word, always word-aligned.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 busy  output  1  a load is in progress.
REQ-012 done  output  1  last load completed with a good checksum.
REQ-013 err  output  1  last load failed on length or checksum.
REQ-014 cpu_run  output  1  CPU reset release, equal to done.
REQ-015 words_loaded  output  16  words written in the current or last load.

Function
REQ-016 Stream format SHALL be: N[15:8], N[7:0], then 4*N data bytes with the MSB of each word first, then one checksum byte.
REQ-017 The FSM SHALL have states IDLE, HDR0, HDR1, DATA, CSUM, DONE and ERR.
REQ-018 start SHALL be sampled only in IDLE, DONE and ERR.
- On start: the next state is HDR0.
- In the same edge: clear words_loaded, the byte index, the running sum, done and err.
REQ-019 start SHALL be ignored in HDR0, HDR1, DATA and CSUM.
REQ-020 in_ready SHALL be 1 exactly in HDR0, HDR1, DATA and CSUM.
- A byte transfers only on in_valid && in_ready.
- No input byte is dropped or duplicated.
REQ-021 busy SHALL be 1 exactly when in_ready is 1.
REQ-022 HDR0 and HDR1 SHALL each latch one header byte and advance on transfer. On the HDR1 transfer:
- N > DEPTH: go to ERR.
- N == 0: go to CSUM.
- Otherwise: go to DATA.
REQ-023 In DATA, the byte index (0..3) SHALL place each byte in the assembly register:
- index 0 to bits [31:24], index 1 to [23:16], index 2 to [15:8], index 3 to [7:0].
- The index wraps 3 -> 0.
REQ-024 Every accepted DATA byte SHALL be added to an 8-bit running sum, modulo 256; header bytes are excluded.
REQ-025 In the cycle after an index-3 transfer, the loader SHALL drive:
- im_we = 1 for exactly one cycle;
- im_addr = {word_idx, 2'b00}, zero-extended to 32 bits;
- im_wdata = the assembled word.
REQ-026 Write outputs SHALL be registered.
- words_loaded increments in the same cycle that im_we is asserted.
- A new byte may be accepted in that same cycle.
REQ-027 The index-3 transfer of word N-1 SHALL move the FSM to CSUM.
- The final im_we pulse occurs during the first CSUM cycle.
REQ-028 The CSUM transfer SHALL move to DONE if the byte equals the running sum, otherwise to ERR.
REQ-029 In DONE: done = 1, cpu_run = 1. In ERR: err = 1, cpu_run = 0. Both hold until the next start or reset.
REQ-030 im_addr and im_wdata SHALL hold their last values when im_we = 0.
REQ-031 im_addr SHALL never exceed (DEPTH-1)*4.

Reset
REQ-032 While rst = 0, the loader SHALL:
- force the state to IDLE;
- set in_ready, im_we, busy, done, err and cpu_run to 0;
- set im_addr, im_wdata and words_loaded to 0;
- clear the assembly register, the index and the sum.
REQ-033 Reset mid-load SHALL abort the load with no further im_we, and cpu_run SHALL stay 0 until a later complete good load.
REQ-034 Outputs SHALL be valid from the first clock edge after rst deasserts.

Verification
REQ-035 Good load: start, then stream 00 02 | 20 08 00 05 | 00 00 00 00 | 2D.
- Two writes: (0x0000_0000, 0x2008_0005) and (0x0000_0004, 0x0000_0000).
- Then done = 1, cpu_run = 1, words_loaded = 2.
REQ-036 Bad checksum: same stream with checksum 2C.
- Both writes still occur.
- Then err = 1, done = 0, cpu_run = 0.
REQ-037 Oversize: with DEPTH = 256, header 01 01.
- ERR right after the HDR1 transfer.
- No im_we pulse; in_ready = 0 afterwards.
REQ-038 Empty program: header 00 00, checksum 00.
- DONE with no im_we pulse and words_loaded = 0.
REQ-039 Backpressure and gaps: a random in_valid gap pattern and a start pulse issued mid-DATA.
- Data identical to REQ-035; the mid-load start has no effect.
REQ-040 Reset mid-load: rst = 0 after 5 data bytes, then release, then the REQ-035 stream.
- All outputs are 0 during reset.
- The following load completes identically to REQ-035.
